// File: rtl/vip_pkg.sv
// Shared constants and types for the gray/Gaussian video front-end.
package vip_pkg;

    typedef logic [7:0] pixel_t;

    // Luma weights (sum to 256) and rounding for the >>8 normalisation.
    localparam logic [15:0] LUMA_COEF_R = 16'd77;
    localparam logic [15:0] LUMA_COEF_G = 16'd150;
    localparam logic [15:0] LUMA_COEF_B = 16'd29;
    localparam logic [15:0] LUMA_ROUND  = 16'd128;
    localparam int          LUMA_SHIFT  = 8;

    // Separable 3x3 Gaussian [1 2 1] x [1 2 1], normalised by >>4 with rounding.
    localparam logic [11:0] GAUSS_K_OUTER = 12'd1;
    localparam logic [11:0] GAUSS_K_INNER = 12'd2;
    localparam logic [11:0] GAUSS_ROUND   = 12'd8;
    localparam int          GAUSS_SHIFT   = 4;

    // Input-to-output latency in clocks.
    localparam int LAT = 7;

    // One 1-2-1 pass of the separable kernel.
    function automatic logic [11:0] tri_sum(logic [11:0] outer_a, logic [11:0] inner,
                                            logic [11:0] outer_b);
        return outer_a * GAUSS_K_OUTER + inner * GAUSS_K_INNER + outer_b * GAUSS_K_OUTER;
    endfunction

endpackage

// File: rtl/vip_line_buffer.sv
// Single-clock line buffer: one write and one registered read per enable.
module vip_line_buffer
    import vip_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    pixel_t mem [DEPTH];

    // Storage write.
    // NOTE: the RAM array has no reset so it maps onto block memory; stale contents are masked downstream.
    always_ff @(posedge clk) begin
        if (en) mem[waddr] <= wdata;
    end

    // Registered read; returns the pre-write contents when raddr == waddr.
    // NOTE: non-blocking assignment keeps read-before-write ordering independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (en) rdata <= mem[raddr];
    end

endmodule

// File: rtl/vip_gray_gauss_frontend.sv
// RGB888 -> luma -> 3x3 Gaussian front-end, 7-clock latency.
// Optional: define GAUSS_BYPASS_EN to add the gauss_bypass port (raw luma passthrough).
module vip_gray_gauss_frontend
    import vip_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_red,
    input  logic [7:0] per_img_green,
    input  logic [7:0] per_img_blue,
`ifdef GAUSS_BYPASS_EN
    input  logic       gauss_bypass,
`endif
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_gray
);

    localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int ROW_W = $clog2(IMG_VDISP + 1);

    logic [LAT-1:0]     vsync_sr, href_sr, clken_sr;
    logic [15:0]        prod_r, prod_g, prod_b, luma_sum;
    pixel_t             luma, y_cur, lb1_q, lb2_q, gray_q, filtered, result;
    logic               luma_clken, href_rise, href_fall, vsync_rise;
    logic [COL_W-1:0]   col_cnt, col_cur, col_prev;
    logic [ROW_W-1:0]   row_cnt;
    logic               row_ok1, row_ok2, col_ok1, col_ok2;
    logic [2:0]         row_en, col_en;
    logic [2:0][7:0]    win_cur, win_mid, win_old;
    logic [2:0][2:0][7:0] tap;
    logic [2:0][11:0]   row_sum;
    logic [11:0]        total;

    // Strobe delay lines, independent of the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr <= '0;
            href_sr  <= '0;
            clken_sr <= '0;
        end else begin
            vsync_sr <= {vsync_sr[LAT-2:0], per_frame_vsync};
            href_sr  <= {href_sr[LAT-2:0],  per_frame_href};
            clken_sr <= {clken_sr[LAT-2:0], per_frame_clken};
        end
    end

    // Luma: multiply, sum with rounding, shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            luma_sum <= '0;
            luma     <= '0;
        end else begin
            prod_r   <= 16'(per_img_red)   * LUMA_COEF_R;
            prod_g   <= 16'(per_img_green) * LUMA_COEF_G;
            prod_b   <= 16'(per_img_blue)  * LUMA_COEF_B;
            luma_sum <= prod_r + prod_g + prod_b + LUMA_ROUND;
            luma     <= 8'(luma_sum >> LUMA_SHIFT);
        end
    end

    // Strobes aligned with the luma value.
    assign luma_clken = clken_sr[2];
    assign href_rise  = href_sr[2]  & ~href_sr[3];
    assign href_fall  = ~href_sr[2] & href_sr[3];
    assign vsync_rise = vsync_sr[2] & ~vsync_sr[3];
    assign col_cur    = href_rise ? '0 : col_cnt;

    // Column / row position of the pixel currently at the luma stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (luma_clken)     col_cnt <= col_cur + COL_W'(1);
            else if (href_rise) col_cnt <= '0;
            if (vsync_rise)     row_cnt <= '0;
            else if (href_fall && row_cnt != ROW_W'(IMG_VDISP)) row_cnt <= row_cnt + ROW_W'(1);
        end
    end

    // Buffer 1 delays luma by one line. Buffer 2 takes buffer 1's registered output,
    // which belongs to the previous pixel, so it is written at the previous address.
    vip_line_buffer #(.DEPTH(IMG_HDISP), .ADDR_W(COL_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (luma_clken),
        .waddr (col_cur),
        .raddr (col_cur),
        .wdata (luma),
        .rdata (lb1_q)
    );

    vip_line_buffer #(.DEPTH(IMG_HDISP), .ADDR_W(COL_W)) u_lb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (luma_clken),
        .waddr (col_prev),
        .raddr (col_cur),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    // Window columns: index 0 = row r-2, 1 = row r-1, 2 = row r.
    assign win_cur = {y_cur, lb1_q, lb2_q};

    // Window shift and edge flags, advanced once per luma pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cur    <= '0;
            win_mid  <= '0;
            win_old  <= '0;
            col_prev <= '0;
            row_ok1  <= 1'b0;
            row_ok2  <= 1'b0;
            col_ok1  <= 1'b0;
            col_ok2  <= 1'b0;
        end else if (luma_clken) begin
            y_cur    <= luma;
            win_mid  <= win_cur;
            win_old  <= win_mid;
            col_prev <= col_cur;
            row_ok1  <= (row_cnt != '0);
            row_ok2  <= (row_cnt >= ROW_W'(2));
            col_ok1  <= (col_cur != '0);
            col_ok2  <= (col_cur >= COL_W'(2));
        end
    end

    assign row_en = {1'b1, row_ok1, row_ok2};
    assign col_en = {1'b1, col_ok1, col_ok2};

    // Taps outside the frame (negative row/col) contribute zero.
    // NOTE: defaulting the whole array first keeps every path assigned, so no latch is inferred.
    always_comb begin
        tap = '0;
        for (int i = 0; i < 3; i++) begin
            if (row_en[i] && col_en[0]) tap[i][0] = win_old[i];
            if (row_en[i] && col_en[1]) tap[i][1] = win_mid[i];
            if (row_en[i])              tap[i][2] = win_cur[i];
        end
    end

    // Adder tree: horizontal 1-2-1 per row, then vertical 1-2-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sum <= '0;
            total   <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                row_sum[i] <= tri_sum(12'(tap[i][0]), 12'(tap[i][1]), 12'(tap[i][2]));
            total <= tri_sum(row_sum[0], row_sum[1], row_sum[2]);
        end
    end

    assign filtered = 8'((total + GAUSS_ROUND) >> GAUSS_SHIFT);

`ifdef GAUSS_BYPASS_EN
    logic [LAT-2:0] byp_sr;
    pixel_t         byp_a, byp_b;

    // Raw luma and the bypass select ride alongside the adder tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_sr <= '0;
            byp_a  <= '0;
            byp_b  <= '0;
        end else begin
            byp_sr <= {byp_sr[LAT-3:0], gauss_bypass};
            byp_a  <= y_cur;
            byp_b  <= byp_a;
        end
    end

    assign result = byp_sr[LAT-2] ? byp_b : filtered;
`else
    assign result = filtered;
`endif

    // Output register; gray is forced to 0 outside valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gray_q <= '0;
        else        gray_q <= clken_sr[LAT-2] ? result : '0;
    end

    assign post_frame_vsync = vsync_sr[LAT-1];
    assign post_frame_href  = href_sr[LAT-1];
    assign post_frame_clken = clken_sr[LAT-1];
    assign post_img_gray    = gray_q;

endmodule

// File: tb/tb_vip_gray_gauss_frontend.sv
// Self-checking bench for vip_gray_gauss_frontend on a reduced 16x10 frame.
`timescale 1ns/1ps
module tb_vip_gray_gauss_frontend;

    localparam int W   = 16;
    localparam int H   = 10;
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vs = 1'b0, hr = 1'b0, ce = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
`ifdef GAUSS_BYPASS_EN
    logic       byp = 1'b0;
`endif
    logic       post_vs, post_hr, post_ce;
    logic [7:0] post_gray;

    always #5 clk = ~clk;

    vip_gray_gauss_frontend #(.IMG_HDISP(W), .IMG_VDISP(H)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vs),
        .per_frame_href   (hr),
        .per_frame_clken  (ce),
        .per_img_red      (r_in),
        .per_img_green    (g_in),
        .per_img_blue     (b_in),
`ifdef GAUSS_BYPASS_EN
        .gauss_bypass     (byp),
`endif
        .post_frame_vsync (post_vs),
        .post_frame_href  (post_hr),
        .post_frame_clken (post_ce),
        .post_img_gray    (post_gray)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int img_r [H][W];
    int img_g [H][W];
    int img_b [H][W];
    int y_ref [H][W];
    int got   [H][W];

    function automatic int luma(int r, int g, int b);
        return (77 * r + 150 * g + 29 * b + 128) >> 8;
    endfunction

    // Full 3x3 convolution with out-of-frame taps as zero.
    function automatic int gauss_at(int r, int c);
        int k [3] = '{1, 2, 1};
        int acc = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (r - 2 + i >= 0 && c - 2 + j >= 0)
                    acc += k[i] * k[j] * y_ref[r - 2 + i][c - 2 + j];
        return (acc + 8) >> 4;
    endfunction

    // kind 0: gray 160, 1: pure red, 2: single 160 impulse at (5,5)
    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img_r[r][c] = (kind == 0) ? 160 : (kind == 1) ? 255 : (r == 5 && c == 5) ? 160 : 0;
                img_g[r][c] = (kind == 0) ? 160 : (kind == 1) ? 0   : (r == 5 && c == 5) ? 160 : 0;
                img_b[r][c] = (kind == 0) ? 160 : (kind == 1) ? 0   : (r == 5 && c == 5) ? 160 : 0;
            end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                y_ref[r][c] = luma(img_r[r][c], img_g[r][c], img_b[r][c]);
    endtask

    // ---------------- output monitor ----------------
    logic [2:0] hist [$];
    int         exp_q [$];
    logic [2:0] h_old;
    int         pos = 0;
    int         e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
            repeat (LAT) hist.push_back(3'b000);
            exp_q.delete();
            pos = 0;
            check("reset_outputs", {post_vs, post_hr, post_ce, post_gray}, 0);
        end else begin
            hist.push_back({vs, hr, ce});
            h_old = hist.pop_front();
            check("strobes_delay7", {post_vs, post_hr, post_ce}, h_old);
            if (post_vs) pos = 0;
            if (post_ce) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("gray_vs_model", post_gray, e);
                end
                if (pos < W * H) got[pos / W][pos % W] = int'(post_gray);
                pos++;
            end else begin
                check("gray_zero_when_idle", post_gray, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame of the current image; stop_pix >= 0 pulses reset after that many pixels.
    task automatic run_frame(input bit gaps, input bit bypass, input int stop_pix);
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(bypass ? y_ref[r][c] : gauss_at(r, c));
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < H; r++) begin
            hr = 1'b1;
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    ce = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                ce   = 1'b1;
                r_in = 8'(img_r[r][c]);
                g_in = 8'(img_g[r][c]);
                b_in = 8'(img_b[r][c]);
                tick();
                n++;
                if (n == stop_pix) begin
                    rst_n = 1'b0;
                    vs = 1'b0;
                    hr = 1'b0;
                    ce = 1'b0;
                    repeat (3) tick();
                    rst_n = 1'b1;
                    repeat (3) tick();
                    return;
                end
            end
            ce = 1'b0;
            hr = 1'b0;
            repeat (4) tick();
        end
        repeat (LAT + 5) tick();
    endtask

    task automatic frame_done(input string tag);
        check({tag, "_clken_count"}, pos, W * H);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();

        // Pin the model against hand-computed values.
        check("model_luma_gray", luma(160, 160, 160), 160);
        check("model_luma_red", luma(255, 0, 0), 77);
        fill(1);
        check("model_red_0_0", gauss_at(0, 0), 5);
        check("model_red_0_5", gauss_at(0, 5), 19);
        fill(2);
        check("model_imp_6_6", gauss_at(6, 6), 40);

        // 1: flat gray
        fill(0);
        run_frame(1'b0, 1'b0, -1);
        frame_done("gray");
        check("gray_5_5", got[5][5], 160);
        check("gray_0_0", got[0][0], 10);
        check("gray_0_1", got[0][1], 30);
        check("gray_1_1", got[1][1], 90);

        // 2: pure red
        fill(1);
        run_frame(1'b0, 1'b0, -1);
        frame_done("red");
        check("red_0_0", got[0][0], 5);
        check("red_0_5", got[0][5], 19);
        check("red_4_4", got[4][4], 77);

        // 3: impulse
        fill(2);
        run_frame(1'b0, 1'b0, -1);
        frame_done("imp");
        check("imp_5_5", got[5][5], 10);
        check("imp_5_6", got[5][6], 20);
        check("imp_6_6", got[6][6], 40);
        check("imp_7_7", got[7][7], 10);
        check("imp_4_4", got[4][4], 0);
        check("imp_8_8", got[8][8], 0);

        // 4: clken gaps inside lines
        fill(0);
        run_frame(1'b1, 1'b0, -1);
        frame_done("gap_gray");
        check("gap_gray_5_5", got[5][5], 160);
        fill(2);
        run_frame(1'b1, 1'b0, -1);
        frame_done("gap_imp");
        check("gap_imp_6_6", got[6][6], 40);

        // 5: reset mid-frame, then a clean frame
        fill(0);
        run_frame(1'b0, 1'b0, 3 * W + 4);
        fill(2);
        run_frame(1'b1, 1'b0, -1);
        frame_done("post_reset");
        check("post_reset_6_6", got[6][6], 40);
        check("post_reset_7_7", got[7][7], 10);

`ifdef GAUSS_BYPASS_EN
        // 6: bypass passes raw luma
        byp = 1'b1;
        fill(2);
        run_frame(1'b0, 1'b1, -1);
        frame_done("bypass");
        check("bypass_5_5", got[5][5], 160);
        check("bypass_6_6", got[6][6], 0);
        byp = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
